t9990_bus_bridge: RTL and testbench

Bridge between the asynchronous MSX cartridge I/O bus and the T9990 CPU port (CSR_n/CSW_n/MODE/CD_IN/CD_OUT/WAIT_n). It sits directly upstream of T9990: it synchronises Z80 I/O strobes into CLK, decodes the 16-port window, and drives one clean T9990 read or write strobe per bus access. It holds the Z80 in wait until the VDP access completes, and returns read data on the bus.

---
 rtl/t9990_bus_bridge_if.sv | 33 +++
 rtl/t9990_bus_bridge.sv | 149 ++++++++++++++
 tb/tb_t9990_bus_bridge.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/t9990_bus_bridge_if.sv
// Signal bundle between the MSX cartridge I/O bus, the bus bridge and the T9990 CPU port.
// The bridge connects through the slave modport; the bus/VDP side uses master.
interface t9990_bus_bridge_if;
    logic       BUS_IORQ_n;
    logic       BUS_RD_n;
    logic       BUS_WR_n;
    logic       BUS_M1_n;
    logic [7:0] BUS_ADDR;
    logic [7:0] BUS_DIN;
    logic [7:0] BUS_DOUT;
    logic       BUS_DOUT_OE;
    logic       BUS_WAIT_n;
    logic       CSR_n;
    logic       CSW_n;
    logic [3:0] MODE;
    logic [7:0] CD_IN;
    logic [7:0] CD_OUT;
    logic       WAIT_n;

    modport slave (
        input  BUS_IORQ_n, BUS_RD_n, BUS_WR_n, BUS_M1_n, BUS_ADDR, BUS_DIN,
        input  CD_OUT, WAIT_n,
        output BUS_DOUT, BUS_DOUT_OE, BUS_WAIT_n,
        output CSR_n, CSW_n, MODE, CD_IN
    );

    modport master (
        output BUS_IORQ_n, BUS_RD_n, BUS_WR_n, BUS_M1_n, BUS_ADDR, BUS_DIN,
        output CD_OUT, WAIT_n,
        input  BUS_DOUT, BUS_DOUT_OE, BUS_WAIT_n,
        input  CSR_n, CSW_n, MODE, CD_IN
    );
endinterface

// File: rtl/t9990_bus_bridge.sv
// Z80 I/O bus to T9990 CPU-port bridge: synchronises bus strobes, decodes a 16-port window
// and issues exactly one clean VDP read/write strobe per bus access, holding the Z80 in WAIT.
module t9990_bus_bridge #(
    parameter logic [7:0] BASE_ADDR     = 8'h60,
    parameter int         STROBE_CYCLES = 4
) (
    input  logic              CLK,
    input  logic              RESET_n,
    input  logic              ENABLE,
    t9990_bus_bridge_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        HOLD   = 2'd2
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(STROBE_CYCLES - 1);

    // Bit order: {IORQ_n, RD_n, WR_n, M1_n}
    logic [3:0] raw_strobes;
    logic [3:0] meta_reg;
    logic [3:0] sync_reg;

    assign raw_strobes = {bus.BUS_IORQ_n, bus.BUS_RD_n, bus.BUS_WR_n, bus.BUS_M1_n};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sync
            always_ff @(posedge CLK or negedge RESET_n) begin
                if (!RESET_n) begin
                    meta_reg[gi] <= 1'b1;
                    sync_reg[gi] <= 1'b1;
                end else begin
                    meta_reg[gi] <= raw_strobes[gi];
                    sync_reg[gi] <= meta_reg[gi];
                end
            end
        end
    endgenerate

    logic sync_iorq_n;
    logic sync_rd_n;
    logic sync_wr_n;
    logic sync_m1_n;
    assign sync_iorq_n = sync_reg[3];
    assign sync_rd_n   = sync_reg[2];
    assign sync_wr_n   = sync_reg[1];
    assign sync_m1_n   = sync_reg[0];

    // RD and WR both asserted is treated as no access at all.
    logic hit;
    assign hit = !sync_iorq_n && sync_m1_n && (sync_rd_n ^ sync_wr_n)
              && (bus.BUS_ADDR[7:4] == BASE_ADDR[7:4]) && ENABLE;

    logic bus_released;
    assign bus_released = sync_iorq_n && sync_rd_n && sync_wr_n;

    state_t     state_reg, state_next;
    logic [3:0] cnt_reg, cnt_next;
    logic       is_read_reg, is_read_next;
    logic [3:0] mode_reg, mode_next;
    logic [7:0] cd_in_reg, cd_in_next;
    logic [7:0] dout_reg, dout_next;
    logic       csr_n_reg, csr_n_next;
    logic       csw_n_reg, csw_n_next;
    logic       bus_wait_n_reg, bus_wait_n_next;
    logic       dout_oe_reg, dout_oe_next;

    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        is_read_next = is_read_reg;
        mode_next    = mode_reg;
        cd_in_next   = cd_in_reg;
        dout_next    = dout_reg;

        unique case (state_reg)
            IDLE: begin
                if (hit) begin
                    state_next   = STROBE;
                    cnt_next     = 4'd0;
                    mode_next    = bus.BUS_ADDR[3:0];
                    is_read_next = !sync_rd_n;
                    if (!sync_wr_n) begin
                        cd_in_next = bus.BUS_DIN;
                    end
                end
            end
            STROBE: begin
                if (cnt_reg != 4'hF) begin
                    cnt_next = cnt_reg + 4'd1;
                end
                // WAIT_n is used unregistered so a VDP hold takes effect in the same cycle.
                if ((cnt_reg >= LAST_CNT) && bus.WAIT_n) begin
                    state_next = HOLD;
                    if (is_read_reg) begin
                        dout_next = bus.CD_OUT;
                    end
                end
            end
            HOLD: begin
                if (bus_released) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Outputs are registered from the next state so they change cleanly on the clock edge.
        csr_n_next      = !((state_next == STROBE) && is_read_next);
        csw_n_next      = !((state_next == STROBE) && !is_read_next);
        bus_wait_n_next = (state_next != STROBE);
        dout_oe_next    = (state_next == HOLD) && is_read_next;
    end

    always_ff @(posedge CLK or negedge RESET_n) begin
        if (!RESET_n) begin
            state_reg      <= IDLE;
            cnt_reg        <= 4'd0;
            is_read_reg    <= 1'b0;
            mode_reg       <= 4'd0;
            cd_in_reg      <= 8'h00;
            dout_reg       <= 8'hFF;
            csr_n_reg      <= 1'b1;
            csw_n_reg      <= 1'b1;
            bus_wait_n_reg <= 1'b1;
            dout_oe_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            is_read_reg    <= is_read_next;
            mode_reg       <= mode_next;
            cd_in_reg      <= cd_in_next;
            dout_reg       <= dout_next;
            csr_n_reg      <= csr_n_next;
            csw_n_reg      <= csw_n_next;
            bus_wait_n_reg <= bus_wait_n_next;
            dout_oe_reg    <= dout_oe_next;
        end
    end

    assign bus.CSR_n       = csr_n_reg;
    assign bus.CSW_n       = csw_n_reg;
    assign bus.MODE        = mode_reg;
    assign bus.CD_IN       = cd_in_reg;
    assign bus.BUS_DOUT    = dout_reg;
    assign bus.BUS_DOUT_OE = dout_oe_reg;
    assign bus.BUS_WAIT_n  = bus_wait_n_reg;
endmodule

// File: tb/tb_t9990_bus_bridge.sv
// Scoreboard bench for t9990_bus_bridge: bus accesses push expected VDP transactions,
// a negedge monitor pops and compares them when each strobe completes.
module tb_t9990_bus_bridge;
    localparam int SC = 4;

    logic CLK     = 1'b0;
    logic RESET_n = 1'b0;
    logic ENABLE  = 1'b1;

    t9990_bus_bridge_if bus ();

    t9990_bus_bridge #(
        .BASE_ADDR    (8'h60),
        .STROBE_CYCLES(SC)
    ) dut (
        .CLK    (CLK),
        .RESET_n(RESET_n),
        .ENABLE (ENABLE),
        .bus    (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit         is_read;
        logic [3:0] mode;
        logic [7:0] data;
        int         len;
    } exp_t;

    exp_t exp_q[$];
    exp_t e;

    int n_checks = 0;
    int n_pass   = 0;

    int cyc          = 0;
    int t_assert     = 0;
    int wait_cycles  = 0;
    int strobe_cnt   = 0;
    int low_cnt      = 0;
    int oe_cnt       = 0;
    int last_oe_len  = 0;
    int last_end_cyc = -100;
    bit in_strobe    = 0;
    bit overlap      = 0;
    bit wait_bad     = 0;
    bit chk_gap      = 0;
    bit any_wait_low = 0;
    bit any_oe       = 0;
    logic       cur_read;
    logic [3:0] cur_mode;
    logic [7:0] cur_cd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    always @(posedge CLK) cyc++;

    // Monitor and VDP model: sampled on the falling edge, away from the active edge.
    always @(negedge CLK) begin
        if (!RESET_n) begin
            in_strobe  = 0;
            low_cnt    = 0;
            oe_cnt     = 0;
            bus.WAIT_n = 1'b1;
        end else begin
            if (!bus.BUS_WAIT_n) any_wait_low = 1;
            if (bus.BUS_DOUT_OE) begin
                any_oe = 1;
                oe_cnt++;
            end else if (oe_cnt > 0) begin
                last_oe_len = oe_cnt;
                oe_cnt      = 0;
            end
            if (!bus.CSR_n || !bus.CSW_n) begin
                if (!in_strobe) begin
                    in_strobe = 1;
                    low_cnt   = 0;
                    strobe_cnt++;
                    overlap   = 0;
                    wait_bad  = 0;
                    cur_read  = !bus.CSR_n;
                    cur_mode  = bus.MODE;
                    cur_cd    = bus.CD_IN;
                    check("detect_latency", 32'((cyc - t_assert) inside {[3:4]}), 1);
                    if (chk_gap) begin
                        check("strobe_gap_ge4", 32'((cyc - last_end_cyc) >= 4), 1);
                        chk_gap = 0;
                    end
                end
                low_cnt++;
                if (!bus.CSR_n && !bus.CSW_n) overlap = 1;
                if (bus.BUS_WAIT_n) wait_bad = 1;
                bus.WAIT_n = (low_cnt > wait_cycles);
            end else if (in_strobe) begin
                in_strobe    = 0;
                last_end_cyc = cyc;
                bus.WAIT_n   = 1'b1;
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    $display("txn %s mode=%0h data=%02h len=%0d", cur_read ? "RD" : "WR",
                             cur_mode, cur_read ? bus.BUS_DOUT : cur_cd, low_cnt);
                    check("direction", cur_read, e.is_read);
                    check("mode", cur_mode, e.mode);
                    check("strobe_len", low_cnt, e.len);
                    check("csr_csw_overlap", overlap, 0);
                    check("bus_wait_during_strobe", wait_bad, 0);
                    check("bus_wait_released", bus.BUS_WAIT_n, 1);
                    if (e.is_read) begin
                        check("read_dout", bus.BUS_DOUT, e.data);
                        check("read_oe", bus.BUS_DOUT_OE, 1);
                    end else begin
                        check("write_cd_in", cur_cd, e.data);
                        check("write_oe_low", bus.BUS_DOUT_OE, 0);
                    end
                end
            end
        end
    end

    task automatic release_now();
        bus.BUS_IORQ_n = 1'b1;
        bus.BUS_RD_n   = 1'b1;
        bus.BUS_WR_n   = 1'b1;
        bus.BUS_M1_n   = 1'b1;
    endtask

    task automatic bus_start(input bit rd, input logic [7:0] addr, input logic [7:0] din,
                             input bit m1_n);
        @(negedge CLK);
        #2;
        bus.BUS_ADDR   = addr;
        bus.BUS_DIN    = din;
        bus.BUS_M1_n   = m1_n;
        bus.BUS_IORQ_n = 1'b0;
        if (rd) bus.BUS_RD_n = 1'b0;
        else    bus.BUS_WR_n = 1'b0;
        t_assert = cyc;
    endtask

    task automatic wait_bus_wait(input logic level, output bit ok);
        ok = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge CLK);
            #2;
            if (bus.BUS_WAIT_n === level) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic io_access(input bit rd, input logic [7:0] addr, input logic [7:0] data,
                             input int wcyc, input int len);
        exp_t x;
        bit   ok;
        x.is_read = rd;
        x.mode    = addr[3:0];
        x.data    = data;
        x.len     = len;
        exp_q.push_back(x);
        wait_cycles = wcyc;
        bus.WAIT_n  = (wcyc == 0);
        if (rd) bus.CD_OUT = data;
        bus_start(rd, addr, rd ? 8'h00 : data, 1'b1);
        wait_bus_wait(1'b0, ok);
        check("bus_wait_asserted", ok, 1);
        wait_bus_wait(1'b1, ok);
        check("bus_wait_deasserted", ok, 1);
        release_now();
    endtask

    task automatic miss_access(input string tag, input bit rd, input logic [7:0] addr,
                               input bit m1_n, input logic en);
        int sc0;
        sc0          = strobe_cnt;
        ENABLE       = en;
        any_wait_low = 0;
        any_oe       = 0;
        bus_start(rd, addr, 8'hA5, m1_n);
        repeat (10) @(negedge CLK);
        #2;
        release_now();
        repeat (6) @(negedge CLK);
        $display("txn miss %s addr=%02h", tag, addr);
        check({tag, "_no_strobe"}, strobe_cnt, sc0);
        check({tag, "_no_wait"}, any_wait_low, 0);
        check({tag, "_no_oe"}, any_oe, 0);
        ENABLE = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected earlier finish");
        $fatal(1);
    end

    initial begin
        bit ok;
        int sc0;
        release_now();
        bus.BUS_ADDR = 8'h00;
        bus.BUS_DIN  = 8'h00;
        bus.CD_OUT   = 8'h00;
        bus.WAIT_n   = 1'b1;

        repeat (3) @(negedge CLK);
        check("rst_csr_n", bus.CSR_n, 1);
        check("rst_csw_n", bus.CSW_n, 1);
        check("rst_mode", bus.MODE, 0);
        check("rst_cd_in", bus.CD_IN, 8'h00);
        check("rst_dout", bus.BUS_DOUT, 8'hFF);
        check("rst_dout_oe", bus.BUS_DOUT_OE, 0);
        check("rst_bus_wait_n", bus.BUS_WAIT_n, 1);
        #2;
        RESET_n = 1'b1;
        repeat (3) @(negedge CLK);

        // Plain write, no VDP wait.
        io_access(1'b0, 8'h60, 8'h5A, 0, 4);
        repeat (4) @(negedge CLK);
        check("hold_cd_in", bus.CD_IN, 8'h5A);

        // Read with VDP WAIT_n low for 6 strobe cycles.
        last_oe_len = 0;
        io_access(1'b1, 8'h63, 8'hC3, 6, 7);
        repeat (6) @(negedge CLK);
        check("read_oe_len", last_oe_len, 3);
        check("hold_mode", bus.MODE, 3);
        check("hold_dout", bus.BUS_DOUT, 8'hC3);

        // Accesses that must not decode.
        miss_access("port70", 1'b0, 8'h70, 1'b1, 1'b1);
        miss_access("m1_low", 1'b1, 8'h60, 1'b0, 1'b1);
        miss_access("disabled", 1'b0, 8'h60, 1'b1, 1'b0);

        // Back-to-back writes with one bus idle cycle between them.
        io_access(1'b0, 8'h6F, 8'h11, 0, 4);
        chk_gap = 1;
        io_access(1'b0, 8'h6F, 8'h22, 0, 4);
        check("gap_checked", chk_gap, 0);
        repeat (6) @(negedge CLK);

        // Bus releases during the strobe: access still completes, OE pulses once.
        last_oe_len = 0;
        exp_q.push_back('{is_read: 1'b1, mode: 4'h1, data: 8'h3C, len: 4});
        wait_cycles = 0;
        bus.WAIT_n  = 1'b1;
        bus.CD_OUT  = 8'h3C;
        bus_start(1'b1, 8'h61, 8'h00, 1'b1);
        wait_bus_wait(1'b0, ok);
        check("early_rel_wait_asserted", ok, 1);
        @(negedge CLK);
        #2;
        release_now();
        repeat (10) @(negedge CLK);
        check("early_rel_oe_len", last_oe_len, 1);
        check("early_rel_idle_wait", bus.BUS_WAIT_n, 1);

        // Reset in the middle of a write.
        wait_cycles = 0;
        bus.WAIT_n  = 1'b1;
        bus_start(1'b0, 8'h65, 8'h99, 1'b1);
        wait_bus_wait(1'b0, ok);
        check("rst_mid_wait_asserted", ok, 1);
        @(negedge CLK);
        #2;
        check("pre_rst_mode", bus.MODE, 5);
        check("pre_rst_cd_in", bus.CD_IN, 8'h99);
        check("pre_rst_csw_low", bus.CSW_n, 0);
        RESET_n = 1'b0;
        #1;
        check("mid_rst_csw_n", bus.CSW_n, 1);
        check("mid_rst_bus_wait_n", bus.BUS_WAIT_n, 1);
        check("mid_rst_mode", bus.MODE, 0);
        check("mid_rst_cd_in", bus.CD_IN, 8'h00);
        release_now();
        repeat (2) @(negedge CLK);
        #2;
        RESET_n = 1'b1;
        sc0 = strobe_cnt;
        repeat (12) @(negedge CLK);
        check("no_retry_after_rst", strobe_cnt, sc0);
        $display("txn reset-abort write port 65h");

        // Bridge still works after the abort.
        io_access(1'b0, 8'h64, 8'h77, 0, 4);
        repeat (6) @(negedge CLK);

        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
